mem_access_stage: RTL
=====================

# mem_access_stage

Memory-stage data-access unit between the EX/MEM pipeline register and the MEM/WB pipeline register. Converts load/store requests into word-aligned requests on a data-memory bus with valid/ready handshake. Stalls the pipeline until the bus completes, and sign- or zero-extends load data into `ReadDataM` for writeback. Misaligned, illegal-width and timed-out accesses are reported as single-cycle fault pulses.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of cycles the unit waits for `dmem_ready` before aborting. Must be 1..255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `MemReadM` in 1: the instruction in MEM is a load.
- `MemWriteM` in 1: the instruction in MEM is a store. `MemReadM` and `MemWriteM` together is illegal and is treated as a fault.
- `funct3M` in 3: access width/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are loads only.
- `ALUresultM` in 32: byte address.
- `WriteDataM` in 32: store data, right-justified.
- `dmem_req` out 1: bus request valid.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: `{ALUresultM[31:2],2'b00}`.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_wstrb` out 4: byte-enable strobes; 0 on reads.
- `dmem_ready` in 1: bus completes the request in this cycle.
- `dmem_rdata` in 32: read word; valid when `dmem_ready`=1.
- `ReadDataM` out 32: extended load result toward MEM/WB.
- `StallM` out 1: freeze PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB.
- `MisalignM` out 1: one-cycle fault pulse, misaligned or illegal access.
- `BusErrM` out 1: one-cycle fault pulse, bus timeout.

## Operation
- FSM states: IDLE, WAIT, DONE.
- An access is active when `MemReadM` or `MemWriteM` is 1.
- Legal access: exactly one of `MemReadM`/`MemWriteM` set, legal `funct3M` for the direction, and aligned address.
  - H/HU requires `addr[0]`=0.
  - W requires `addr[1:0]`=00.
- Illegal access while in IDLE:
  - `MisalignM`=1 for that cycle only, `dmem_req`=0, `StallM`=0, `ReadDataM`=0.
  - FSM stays in IDLE.
- IDLE with a legal access:
  - `dmem_req`=1 combinationally and `StallM`=1.
  - If `dmem_ready`=1 in the same cycle: capture the result and go to DONE.
  - Otherwise go to WAIT and clear the timeout counter.
- WAIT:
  - `dmem_req`=1, `StallM`=1. Request fields are stable because EX/MEM is frozen.
  - Counter increments each cycle.
  - On `dmem_ready`: capture the result and go to DONE.
  - When the counter reaches `TIMEOUT` without `dmem_ready`: drop the request, pulse `BusErrM`, capture 0 and go to DONE.
- DONE:
  - `dmem_req`=0, `StallM`=0, `ReadDataM` = captured value.
  - Next cycle: IDLE unconditionally. The pipeline advances in this DONE cycle, so MEM/WB samples `ReadDataM`.
  - DONE ignores the access inputs, so a back-to-back access starts from IDLE one cycle later.
- Store lane rules, with `a` = `addr[1:0]`:
  - SB: wstrb = `4'b0001<<a`, wdata = `{4{WriteDataM[7:0]}}`.
  - SH: wstrb = `4'b0011<<a`, wdata = `{2{WriteDataM[15:0]}}`.
  - SW: wstrb = 1111, wdata = `WriteDataM`.
- Load extraction: select byte `a` or halfword `a[1]` from `dmem_rdata`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - The result is registered at capture time.
- Stores capture 0 into `ReadDataM`.
- `dmem_addr`, `dmem_we`, `dmem_wdata`, `dmem_wstrb` are 0 whenever `dmem_req`=0.

## Timing
- Reset values: state IDLE, counter 0, captured data 0. `dmem_req`, `dmem_we`, `dmem_wstrb`, `StallM`, `MisalignM`, `BusErrM` and `ReadDataM` are all 0.
- Reset asserted mid-access (WAIT or DONE): the request drops asynchronously and the unit returns to IDLE. No fault pulse is generated.
- Access latency: N+1 cycles total. `StallM` is high for N cycles, where N is the cycle count from request through `dmem_ready` inclusive; DONE adds one cycle. Minimum 2 cycles for zero-wait memory.
- Timeout path: `BusErrM` pulses on the cycle of the DONE transition; DONE follows.
- A `dmem_ready` that arrives while `dmem_req`=0 is ignored.
- Non-memory instructions in IDLE: all outputs 0, no stall.

## Test plan
- LW, addr 0x100, `dmem_ready` same cycle, rdata 0xDEADBEEF:
  - `StallM` high for 1 cycle.
  - Next cycle DONE, `ReadDataM`=0xDEADBEEF.
- LB, addr 0x103, rdata 0x80FF_0000 → `ReadDataM`=0xFFFFFF80.
- LBU, same address and rdata → 0x00000080.
- LHU, addr 0x102, rdata 0x8001_1234 → 0x00008001.
- SH, addr 0x0A2, `WriteDataM`=0x0000ABCD, 3 wait cycles:
  - `dmem_wstrb`=1100, `dmem_wdata`=0xABCDABCD, `dmem_addr`=0x0A0.
  - `StallM` high for 4 cycles, then low in DONE.
- LW at addr 0x101 → `MisalignM` one pulse, `dmem_req` never asserted, `StallM`=0.
- `TIMEOUT`=4, LW, `dmem_ready` held low:
  - Request held 5 cycles, then `BusErrM` pulse.
  - DONE with `ReadDataM`=0, `StallM` low.
- Assert `rst` in the 2nd WAIT cycle of a load: `dmem_req` and `StallM` go 0 immediately; after release, a new LW completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory-stage data-access unit sitting between EX/MEM and MEM/WB. Turns a
// load/store from the MEM stage into a single word-aligned request on a
// valid/ready data bus. The pipeline is stalled while the request is in
// flight, and the load result is extended and registered for writeback.
// Illegal (misaligned, bad width, read+write) accesses and bus timeouts are
// reported as one-cycle fault pulses.
//
// Parameters
//   TIMEOUT     cycles spent in WAIT before the request is abandoned (1..255)
//
// Ports
//   clk, rst    clock; asynchronous active-high reset
//   MemReadM    load in MEM
//   MemWriteM   store in MEM
//   funct3M     width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUresultM  byte address
//   WriteDataM  right-justified store data
//   dmem_req    bus request valid
//   dmem_we     bus write enable
//   dmem_addr   word-aligned bus address
//   dmem_wdata  lane-replicated store data
//   dmem_wstrb  byte strobes (0 on reads)
//   dmem_ready  bus completes the request this cycle
//   dmem_rdata  bus read word, valid with dmem_ready
//   ReadDataM   extended load result toward MEM/WB
//   StallM      freeze front of pipe, bubble into MEM/WB
//   MisalignM   one-cycle pulse: misaligned or illegal access
//   BusErrM     one-cycle pulse: bus timeout
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUresultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] rdata_q;

  logic        access;
  logic        legal;
  logic        width_ok;
  logic        align_ok;
  logic        timeout_hit;
  logic        req;
  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [3:0]  strb;
  logic [31:0] wdata;

  assign lane   = ALUresultM[1:0];
  assign access = MemReadM | MemWriteM;

  // Width legality for the requested direction and natural alignment.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // assignment in always_comb would infer a latch.
    width_ok = 1'b0;
    align_ok = 1'b0;
    case (funct3M)
      3'b000: begin width_ok = 1'b1;       align_ok = 1'b1;            end
      3'b001: begin width_ok = 1'b1;       align_ok = ~lane[0];        end
      3'b010: begin width_ok = 1'b1;       align_ok = (lane == 2'b00); end
      3'b100: begin width_ok = ~MemWriteM; align_ok = 1'b1;            end
      3'b101: begin width_ok = ~MemWriteM; align_ok = ~lane[0];        end
      default: ;
    endcase
  end

  assign legal       = (MemReadM ^ MemWriteM) & width_ok & align_ok;
  assign timeout_hit = (state == WAIT) && (wait_cnt == TIMEOUT_CNT);

  // Combinational outputs are gated by rst so an in-flight request drops the
  // moment reset asserts, even while the EX/MEM inputs still show an access.
  assign req       = ~rst & (((state == IDLE) & legal) | ((state == WAIT) & ~timeout_hit));
  assign StallM    = ~rst & (((state == IDLE) & legal) | (state == WAIT));
  assign MisalignM = ~rst & (state == IDLE) & access & ~legal;
  assign BusErrM   = ~rst & timeout_hit;

  // Load extraction from the returned word.
  always_comb begin
    case (lane)
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      2'd3:    byte_sel = dmem_rdata[31:24];
      default: byte_sel = dmem_rdata[7:0];
    endcase
    half_sel = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_val = '0;
    if (!MemWriteM) begin
      case (funct3M)
        3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
        3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
        3'b010:  load_val = dmem_rdata;
        3'b100:  load_val = {24'd0, byte_sel};
        3'b101:  load_val = {16'd0, half_sel};
        default: load_val = '0;
      endcase
    end
  end

  // Store lane placement: data replicated across lanes, strobes select.
  always_comb begin
    strb  = 4'b1111;
    wdata = WriteDataM;
    case (funct3M)
      3'b000: begin strb = 4'b0001 << lane; wdata = {4{WriteDataM[7:0]}};  end
      3'b001: begin strb = 4'b0011 << lane; wdata = {2{WriteDataM[15:0]}}; end
      default: ;
    endcase
  end

  assign dmem_req   = req;
  assign dmem_we    = req & MemWriteM;
  assign dmem_addr  = req ? {ALUresultM[31:2], 2'b00} : 32'd0;
  assign dmem_wstrb = dmem_we ? strb : 4'b0000;
  assign dmem_wdata = dmem_we ? wdata : 32'd0;
  assign ReadDataM  = (state == DONE) ? rdata_q : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register sees
      // the values from before this edge, independent of statement order.
      case (state)
        IDLE: begin
          if (legal) begin
            if (dmem_ready) begin
              rdata_q <= load_val;
              state   <= DONE;
            end else begin
              wait_cnt <= '0;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (timeout_hit) begin
            rdata_q <= '0;
            state   <= DONE;
          end else if (dmem_ready) begin
            rdata_q <= load_val;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
